// File: rtl/spi_pkg.sv
// Shared definitions for the SPI receive path: default frame length, receiver
// state encoding and the counter-width helper.
package spi_pkg;

  localparam int FRAME_BITS_DEFAULT = 24;

  typedef enum logic [1:0] {
    WAIT_IDLE = 2'd0,
    IDLE      = 2'd1,
    RECEIVE   = 2'd2,
    CHECK     = 2'd3
  } rx_state_t;

  // Smallest number of bits able to hold values 0 .. value-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/spi_rx_interface_if.sv
// Word delivery handshake between the SPI receiver (master modport) and its
// consumer (slave modport).
//
// Handshake: rx_valid rises when a new word is placed on rx_data and holds,
// with rx_data stable, until the first cycle in which rx_ack is high; it then
// drops on the following clock edge. A word loaded in the same cycle as rx_ack
// keeps rx_valid high (the new word is not acknowledged). rx_ack while
// rx_valid is low is ignored.
interface spi_rx_interface_if
  import spi_pkg::*;
#(
  parameter int FRAME_BITS = FRAME_BITS_DEFAULT
);

  logic [FRAME_BITS-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ack;

  modport master (output rx_data, output rx_valid, input rx_ack);
  modport slave  (input rx_data, input rx_valid, output rx_ack);

endinterface

// File: rtl/spi_pin_sync.sv
// Multi-stage synchronizer for one asynchronous SPI pin, with optional
// rising/falling edge detection on the synchronized level. All flops reset to
// the bus-idle level (1).
module spi_pin_sync #(
  parameter int STAGES  = 2,
  parameter bit EDGE_EN = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;

  // synchronizer chain, oldest sample at the top
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) chain <= '1;
    else        chain <= {chain[STAGES-2:0], pin};
  end

  assign level = chain[STAGES-1];

  generate
    if (EDGE_EN) begin : g_edge
      logic prev;

      // one-cycle delayed copy of the synchronized level for edge detection
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev <= 1'b1;
        else        prev <= level;
      end

      assign rise = level & ~prev;
      assign fall = ~level & prev;
    end else begin : g_no_edge
      assign rise = 1'b0;
      assign fall = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/spi_rx_interface.sv
// SPI slave receiver (mode with spi_clock idle high, data sampled on rising
// spi_clock, MSB first). Pins are oversampled in the clk domain; complete
// frames of exactly FRAME_BITS bits are delivered through rx_bus.
// Optional readback of the previous word on miso: define SPI_RX_MISO_EN.
module spi_rx_interface
  import spi_pkg::*;
#(
  parameter int FRAME_BITS  = FRAME_BITS_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      spi_clock,
  input  logic                      spi_data,
  input  logic                      cs_n,
  spi_rx_interface_if.master        rx_bus,
  output logic                      frame_error,
  output logic                      overrun,
  output logic                      busy,
  output logic                      miso,
  output rx_state_t                 state_dbg
);

  localparam int CNT_W    = clog2(FRAME_BITS + 2);
  localparam int SETTLE_W = clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0]    CNT_FULL    = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0]    CNT_LONG    = CNT_W'(FRAME_BITS + 1);
  localparam logic [SETTLE_W-1:0] SETTLE_DONE = SETTLE_W'(SYNC_STAGES + 1);

  // synchronized pins
  logic sclk_level, sclk_rise, sclk_fall;
  logic cs_level, cs_rise, cs_fall;
  logic mosi, mosi_rise_unused, mosi_fall_unused;

  spi_pin_sync #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .pin(spi_clock),
    .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .pin(cs_n),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );

  spi_pin_sync #(.STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .pin(spi_data),
    .level(mosi), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  logic unused_sigs;
  assign unused_sigs = &{1'b0, sclk_level, sclk_fall, mosi_rise_unused, mosi_fall_unused};

  rx_state_t             state, state_next;
  logic [CNT_W-1:0]      bit_cnt;
  logic [FRAME_BITS-1:0] shift;
  logic [FRAME_BITS-1:0] rx_data_q;
  logic                  rx_valid_q;
  logic [SETTLE_W-1:0]   settle_cnt;
  logic                  settled;
  logic                  start_frame, take_bit, end_frame, good_frame, bad_frame;

  // The synchronizers come out of reset showing the idle level, not the pin.
  // Leaving WAIT_IDLE is held off until the chain has been refilled from the
  // real pin, otherwise a cs_n held low across reset would look like a fresh
  // frame start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                       settle_cnt <= '0;
    else if (settle_cnt != SETTLE_DONE) settle_cnt <= settle_cnt + 1'b1;
  end

  assign settled = (settle_cnt == SETTLE_DONE);

  // receiver state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= WAIT_IDLE;
    else        state <= state_next;
  end

  // receiver next-state logic
  always_comb begin
    state_next = state;
    case (state)
      WAIT_IDLE: if (settled && cs_level) state_next = IDLE;
      IDLE:      if (cs_fall)             state_next = RECEIVE;
      RECEIVE:   if (cs_rise)             state_next = CHECK;
      CHECK:                              state_next = IDLE;
      default:                            state_next = WAIT_IDLE;
    endcase
  end

  // receiver control decode
  always_comb begin
    start_frame = 1'b0;
    take_bit    = 1'b0;
    end_frame   = 1'b0;
    good_frame  = 1'b0;
    bad_frame   = 1'b0;
    case (state)
      IDLE:    start_frame = cs_fall;
      RECEIVE: begin
        take_bit  = sclk_rise & ~cs_level;
        end_frame = cs_rise;
      end
      CHECK: begin
        good_frame = (bit_cnt == CNT_FULL);
        bad_frame  = (bit_cnt != CNT_FULL);
      end
      default: ;
    endcase
  end

  // frame assembly, length check and word delivery
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt     <= '0;
      shift       <= '0;
      busy        <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_error <= 1'b0;
      overrun     <= 1'b0;
      if (start_frame) begin
        bit_cnt <= '0;
        shift   <= '0;
        busy    <= 1'b1;
      end
      // counter saturates one past full so an over-long frame stays marked long
      if (take_bit && bit_cnt != CNT_LONG) begin
        bit_cnt <= bit_cnt + 1'b1;
        if (bit_cnt < CNT_FULL) shift <= {shift[FRAME_BITS-2:0], mosi};
      end
      if (end_frame) busy <= 1'b0;
      if (good_frame) begin
        rx_data_q  <= shift;
        rx_valid_q <= 1'b1;
        overrun    <= rx_valid_q & ~rx_bus.rx_ack;
      end else if (rx_bus.rx_ack) begin
        rx_valid_q <= 1'b0;
      end
      if (bad_frame) frame_error <= 1'b1;
    end
  end

  assign rx_bus.rx_data  = rx_data_q;
  assign rx_bus.rx_valid = rx_valid_q;
  assign state_dbg       = state;

`ifdef SPI_RX_MISO_EN
  logic [FRAME_BITS-1:0] tx_shift;

  // readback shifter: loads the last accepted word at frame start and advances
  // on each falling spi_clock after the first sampled bit, so the MSB is on
  // miso for the first rising edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_shift <= '1;
    end else if (start_frame) begin
      tx_shift <= rx_data_q;
    end else if (state == RECEIVE && sclk_fall && bit_cnt != '0) begin
      tx_shift <= {tx_shift[FRAME_BITS-2:0], 1'b1};
    end
  end

  assign miso = (state == RECEIVE) ? tx_shift[FRAME_BITS-1] : 1'b1;
`else
  assign miso = 1'b1;
`endif

endmodule

// File: tb/tb_spi_rx_interface.sv
// Directed bench for spi_rx_interface: 100 MHz clk, 10 MHz SPI master model.
module tb_spi_rx_interface;
  import spi_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic      spi_clock, spi_data, cs_n;
  logic      frame_error, overrun, busy, miso;
  rx_state_t state_dbg;

  spi_rx_interface_if #(.FRAME_BITS(24)) bus ();

  spi_rx_interface #(.FRAME_BITS(24), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .spi_clock(spi_clock), .spi_data(spi_data),
    .cs_n(cs_n), .rx_bus(bus), .frame_error(frame_error), .overrun(overrun),
    .busy(busy), .miso(miso), .state_dbg(state_dbg)
  );

  int checks = 0;
  int errors = 0;
  int lat, errs, ovrs;
  logic [23:0] miso_cap;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic cs_low();
    @(negedge clk);
    cs_n = 1'b0;
    #100;
  endtask

  task automatic clock_bits(input logic [23:0] data, input int first, input int count);
    for (int i = first; i < first + count; i++) begin
      spi_clock = 1'b0;
      spi_data  = (i < 24) ? data[23-i] : 1'b0;
      #50;
      spi_clock = 1'b1;
      if (i < 24) miso_cap[23-i] = miso;
      #50;
    end
  endtask

  // raise cs_n and watch 12 cycles for pulses and the rx_valid rise
  task automatic cs_high_watch(input bit ack_on_load);
    logic prev_v;
    bit   acked;
    #60;
    @(negedge clk);
    cs_n   = 1'b1;
    lat    = -1;
    errs   = 0;
    ovrs   = 0;
    acked  = 1'b0;
    prev_v = bus.rx_valid;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      bus.rx_ack = 1'b0;
      if (frame_error) errs++;
      if (overrun) ovrs++;
      if (bus.rx_valid && !prev_v && lat < 0) lat = c;
      prev_v = bus.rx_valid;
      if (ack_on_load && !acked && !busy) begin
        bus.rx_ack = 1'b1;
        acked = 1'b1;
      end
    end
    #100;
  endtask

  task automatic send_frame(input logic [23:0] data, input int nbits, input bit ack_on_load);
    miso_cap = '0;
    cs_low();
    clock_bits(data, 0, nbits);
    cs_high_watch(ack_on_load);
  endtask

  task automatic ack_pulse();
    @(negedge clk);
    bus.rx_ack = 1'b1;
    @(negedge clk);
    bus.rx_ack = 1'b0;
  endtask

  int busy_seen, state_moves;

  initial begin
    rst_n      = 1'b0;
    cs_n       = 1'b1;
    spi_clock  = 1'b1;
    spi_data   = 1'b0;
    bus.rx_ack = 1'b0;
    miso_cap   = '0;
    #23;
    check("rst_rx_data", 32'(bus.rx_data), 32'h0);
    check("rst_rx_valid", 32'(bus.rx_valid), 32'h0);
    check("rst_frame_error", 32'(frame_error), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_miso", 32'(miso), 32'h1);
    check("rst_state", 32'(state_dbg), 32'(WAIT_IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("settle_state", 32'(state_dbg), 32'(IDLE));

    // spi_clock activity with cs_n high must be ignored
    busy_seen   = 0;
    state_moves = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (c % 5 == 0) spi_clock = ~spi_clock;
      if (busy) busy_seen++;
      if (state_dbg != IDLE) state_moves++;
    end
    check("idle_toggle_busy", 32'(busy_seen), 32'h0);
    check("idle_toggle_state", 32'(state_moves), 32'h0);

    // good frame, latency from cs_n rise
    send_frame(24'hA5C33C, 24, 1'b0);
    check("a5_lat_ok", 32'(lat >= 1 && lat <= 5), 32'h1);
    check("a5_err", 32'(errs), 32'h0);
    check("a5_ovr", 32'(ovrs), 32'h0);
    check("a5_data", 32'(bus.rx_data), 32'hA5C33C);
    check("a5_valid", 32'(bus.rx_valid), 32'h1);
`ifdef SPI_RX_MISO_EN
    check("a5_miso", 32'(miso_cap), 32'h000000);
`else
    check("a5_miso", 32'(miso_cap), 32'hFFFFFF);
`endif

    // short and long frames
    send_frame(24'h111111, 23, 1'b0);
    check("short_err", 32'(errs), 32'h1);
    check("short_data", 32'(bus.rx_data), 32'hA5C33C);
    check("short_valid", 32'(bus.rx_valid), 32'h1);
    send_frame(24'h222222, 25, 1'b0);
    check("long_err", 32'(errs), 32'h1);
    check("long_data", 32'(bus.rx_data), 32'hA5C33C);
    check("long_valid", 32'(bus.rx_valid), 32'h1);

    // acknowledge, then a stray ack with nothing pending
    ack_pulse();
    check("ack_valid", 32'(bus.rx_valid), 32'h0);
    ack_pulse();
    check("stray_ack_valid", 32'(bus.rx_valid), 32'h0);
    check("stray_ack_data", 32'(bus.rx_data), 32'hA5C33C);

    // overrun with no ack
    send_frame(24'h000001, 24, 1'b0);
    check("ovr1_ovr", 32'(ovrs), 32'h0);
    check("ovr1_data", 32'(bus.rx_data), 32'h000001);
    send_frame(24'hFFFFFE, 24, 1'b0);
    check("ovr2_ovr", 32'(ovrs), 32'h1);
    check("ovr2_data", 32'(bus.rx_data), 32'hFFFFFE);
    check("ovr2_valid", 32'(bus.rx_valid), 32'h1);

    // ack coincident with the load: load wins, no overrun
    ack_pulse();
    send_frame(24'h000001, 24, 1'b0);
    check("coin1_ovr", 32'(ovrs), 32'h0);
    send_frame(24'hFFFFFE, 24, 1'b1);
    check("coin2_ovr", 32'(ovrs), 32'h0);
    check("coin2_valid", 32'(bus.rx_valid), 32'h1);
    check("coin2_data", 32'(bus.rx_data), 32'hFFFFFE);

    // zero-bit frame
    send_frame(24'h000000, 0, 1'b0);
    check("zero_err", 32'(errs), 32'h1);
    check("zero_data", 32'(bus.rx_data), 32'hFFFFFE);
    check("zero_valid", 32'(bus.rx_valid), 32'h1);

    // reset in the middle of a frame
    cs_low();
    clock_bits(24'h5A5A5A, 0, 10);
    rst_n = 1'b0;
    #5;
    check("midrst_busy", 32'(busy), 32'h0);
    check("midrst_valid", 32'(bus.rx_valid), 32'h0);
    #20;
    rst_n = 1'b1;
    clock_bits(24'h5A5A5A, 10, 14);
    cs_high_watch(1'b0);
    check("midrst_err", 32'(errs), 32'h0);
    check("midrst_valid_after", 32'(bus.rx_valid), 32'h0);
    check("midrst_data", 32'(bus.rx_data), 32'h0);
    send_frame(24'h123456, 24, 1'b0);
    check("post_rst_data", 32'(bus.rx_data), 32'h123456);
    check("post_rst_valid", 32'(bus.rx_valid), 32'h1);
    check("post_rst_err", 32'(errs), 32'h0);

    // readback of the previous word
    ack_pulse();
    send_frame(24'h0F0F0F, 24, 1'b0);
    send_frame(24'h000000, 24, 1'b0);
    check("rb_data", 32'(bus.rx_data), 32'h000000);
`ifdef SPI_RX_MISO_EN
    check("rb_miso", 32'(miso_cap), 32'h0F0F0F);
`else
    check("rb_miso", 32'(miso_cap), 32'hFFFFFF);
`endif
    check("end_miso_idle", 32'(miso), 32'h1);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
